// File: rtl/iicmb_wb_sequencer_if.sv
// rtl/iicmb_wb_sequencer_if.sv - Wishbone link between the sequencer and the iicmb_m_wb controller
interface iicmb_wb_sequencer_if #(
    parameter int WB_ADDR_WIDTH = 2,
    parameter int WB_DATA_WIDTH = 8
);
    logic                     cyc_o;
    logic                     stb_o;
    logic                     we_o;
    logic [WB_ADDR_WIDTH-1:0] adr_o;
    logic [WB_DATA_WIDTH-1:0] dat_o;
    logic [WB_DATA_WIDTH-1:0] dat_i;
    logic                     ack_i;
    logic                     irq_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o,
        input  dat_i, ack_i, irq_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o,
        output dat_i, ack_i, irq_i
    );
endinterface

// File: rtl/iicmb_wb_sequencer.sv
// rtl/iicmb_wb_sequencer.sv - Wishbone master expanding I2C transaction requests into iicmb_m_wb commands
module iicmb_wb_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    iicmb_wb_sequencer_if.master wb,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_rnw,
    input  logic [3:0]           req_bus,
    input  logic [6:0]           req_addr,
    input  logic [LEN_WIDTH-1:0] req_len,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [7:0]           wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [7:0]           rd_data,
    output logic                 done,
    output logic [1:0]           status
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] S_INIT     = 4'd0;
    localparam logic [3:0] S_IDLE     = 4'd1;
    localparam logic [3:0] S_BUS_DPR  = 4'd2;
    localparam logic [3:0] S_CMD_WR   = 4'd3;
    localparam logic [3:0] S_CMD_WAIT = 4'd4;
    localparam logic [3:0] S_CMD_RD   = 4'd5;
    localparam logic [3:0] S_ADDR_DPR = 4'd6;
    localparam logic [3:0] S_WR_WAIT  = 4'd7;
    localparam logic [3:0] S_WR_DPR   = 4'd8;
    localparam logic [3:0] S_RD_DPR   = 4'd9;
    localparam logic [3:0] S_RD_OUT   = 4'd10;
    localparam logic [3:0] S_DONE     = 4'd11;

    localparam logic [2:0] C_WRITE    = 3'b001;
    localparam logic [2:0] C_READ_ACK = 3'b010;
    localparam logic [2:0] C_READ_NAK = 3'b011;
    localparam logic [2:0] C_START    = 3'b100;
    localparam logic [2:0] C_STOP     = 3'b101;
    localparam logic [2:0] C_SET_BUS  = 3'b110;

    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

    logic [3:0]               state;
    logic [2:0]               cmd;
    logic [3:0]               bus;
    logic [6:0]               addr;
    logic                     rnw;
    logic [LEN_WIDTH-1:0]     remaining;
    logic [7:0]               wbyte;
    logic [1:0]               pend_status;
    logic [1:0]               status_q;
    logic [7:0]               rd_data_q;
    logic                     rd_valid_q;
    logic                     wr_ready_q;
    logic [TW-1:0]            tcount;
    logic                     cyc;
    logic                     we;
    logic [WB_ADDR_WIDTH-1:0] adr;
    logic [WB_DATA_WIDTH-1:0] dat;

    logic                     acc_en;
    logic                     acc_we;
    logic [WB_ADDR_WIDTH-1:0] acc_adr;
    logic [WB_DATA_WIDTH-1:0] acc_dat;
    logic                     acc_done;
    logic                     st_nak;
    logic                     st_al;
    logic                     st_err;

    // Each access state describes the single Wishbone transfer it needs.
    always_comb begin
        acc_en  = 1'b1;
        acc_we  = 1'b1;
        acc_adr = ADR_DPR;
        acc_dat = '0;
        case (state)
            S_INIT:     begin acc_adr = ADR_CSR; acc_dat = WB_DATA_WIDTH'(8'hC0); end
            S_BUS_DPR:  acc_dat = WB_DATA_WIDTH'({4'b0000, bus});
            S_ADDR_DPR: acc_dat = WB_DATA_WIDTH'({addr, rnw});
            S_WR_DPR:   acc_dat = WB_DATA_WIDTH'(wbyte);
            S_RD_DPR:   acc_we  = 1'b0;
            S_CMD_WR:   begin acc_adr = ADR_CMDR; acc_dat = WB_DATA_WIDTH'({5'b00000, cmd}); end
            S_CMD_RD:   begin acc_adr = ADR_CMDR; acc_we = 1'b0; end
            default:    acc_en  = 1'b0;
        endcase
    end

    assign acc_done = cyc && wb.ack_i;
    assign st_nak   = wb.dat_i[6];
    assign st_al    = wb.dat_i[5];
    assign st_err   = wb.dat_i[4];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= S_INIT;
            cmd         <= 3'b000;
            bus         <= 4'h0;
            addr        <= 7'h00;
            rnw         <= 1'b0;
            remaining   <= '0;
            wbyte       <= 8'h00;
            pend_status <= 2'd0;
            status_q    <= 2'd0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            wr_ready_q  <= 1'b0;
            tcount      <= '0;
            cyc         <= 1'b0;
            we          <= 1'b0;
            adr         <= '0;
            dat         <= '0;
        end else begin
            if (cyc) begin
                if (wb.ack_i) begin
                    cyc <= 1'b0;
                    we  <= 1'b0;
                    adr <= '0;
                    dat <= '0;
                end
            end else if (acc_en) begin
                cyc <= 1'b1;
                we  <= acc_we;
                adr <= acc_adr;
                dat <= acc_dat;
            end

            case (state)
                S_INIT: if (acc_done) state <= S_IDLE;
                S_IDLE: if (req_valid) begin
                    rnw         <= req_rnw;
                    bus         <= req_bus;
                    addr        <= req_addr;
                    remaining   <= req_len;
                    pend_status <= 2'd0;
                    state       <= S_BUS_DPR;
                end
                S_BUS_DPR: if (acc_done) begin
                    cmd   <= C_SET_BUS;
                    state <= S_CMD_WR;
                end
                // irq is only looked at once the CMDR write has been acked.
                S_CMD_WR: if (acc_done) begin
                    tcount <= '0;
                    state  <= S_CMD_WAIT;
                end
                S_CMD_WAIT: begin
                    if (wb.irq_i) begin
                        state <= S_CMD_RD;
                    end else if (tcount >= TW'(TIMEOUT_CYCLES - 1)) begin
                        status_q <= 2'd3;
                        state    <= S_DONE;
                    end else begin
                        tcount <= tcount + TW'(1);
                    end
                end
                S_CMD_RD: if (acc_done) begin
                    if (st_al) begin
                        status_q <= 2'd2;
                        state    <= S_DONE;
                    end else if (st_err) begin
                        status_q <= 2'd3;
                        state    <= S_DONE;
                    end else if (st_nak && cmd != C_STOP) begin
                        pend_status <= 2'd1;
                        cmd         <= C_STOP;
                        state       <= S_CMD_WR;
                    end else begin
                        case (cmd)
                            C_SET_BUS: begin cmd <= C_START; state <= S_CMD_WR; end
                            C_START:   state <= S_ADDR_DPR;
                            C_WRITE: begin
                                if (remaining == '0) begin
                                    cmd   <= C_STOP;
                                    state <= S_CMD_WR;
                                end else if (rnw) begin
                                    cmd   <= (remaining == LEN_WIDTH'(1)) ? C_READ_NAK : C_READ_ACK;
                                    state <= S_CMD_WR;
                                end else begin
                                    state <= S_WR_WAIT;
                                end
                            end
                            C_READ_ACK, C_READ_NAK: state <= S_RD_DPR;
                            default: begin
                                status_q <= pend_status;
                                state    <= S_DONE;
                            end
                        endcase
                    end
                end
                S_ADDR_DPR: if (acc_done) begin
                    cmd   <= C_WRITE;
                    state <= S_CMD_WR;
                end
                // The byte transfers on the single cycle wr_ready is high.
                S_WR_WAIT: begin
                    if (wr_ready_q) begin
                        wr_ready_q <= 1'b0;
                        wbyte      <= wr_data;
                        remaining  <= remaining - LEN_WIDTH'(1);
                        state      <= S_WR_DPR;
                    end else if (wr_valid) begin
                        wr_ready_q <= 1'b1;
                    end
                end
                S_WR_DPR: if (acc_done) begin
                    cmd   <= C_WRITE;
                    state <= S_CMD_WR;
                end
                S_RD_DPR: if (acc_done) begin
                    rd_data_q  <= wb.dat_i[7:0];
                    rd_valid_q <= 1'b1;
                    state      <= S_RD_OUT;
                end
                S_RD_OUT: if (rd_ready) begin
                    rd_valid_q <= 1'b0;
                    remaining  <= remaining - LEN_WIDTH'(1);
                    if (remaining == LEN_WIDTH'(1)) begin
                        cmd <= C_STOP;
                    end else begin
                        cmd <= (remaining == LEN_WIDTH'(2)) ? C_READ_NAK : C_READ_ACK;
                    end
                    state <= S_CMD_WR;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_INIT;
            endcase
        end
    end

    assign wb.cyc_o  = cyc;
    assign wb.stb_o  = cyc;
    assign wb.we_o   = we;
    assign wb.adr_o  = adr;
    assign wb.dat_o  = dat;
    assign req_ready = (state == S_IDLE);
    assign done      = (state == S_DONE);
    assign status    = status_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
endmodule

// File: tb/tb_iicmb_wb_sequencer.sv
// tb/tb_iicmb_wb_sequencer.sv - directed bench with an iicmb_m_wb controller and I2C slave model
module tb_iicmb_wb_sequencer;
    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rnw = 1'b0;
    logic [3:0] req_bus = 4'h0;
    logic [6:0] req_addr = 7'h00;
    logic [7:0] req_len = 8'h00;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       done;
    logic [1:0] status;

    iicmb_wb_sequencer_if #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8)) wb ();

    iicmb_wb_sequencer #(
        .WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .LEN_WIDTH(8), .TIMEOUT_CYCLES(200)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .wb(wb),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_bus(req_bus), .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .status(status)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Controller and slave model; log entries are {adr, dat}.
    logic [9:0] wlog [0:4095];
    int         wcnt = 0;
    logic [7:0] m_dpr = 8'h00;
    logic [7:0] m_stat = 8'h00;
    logic [2:0] m_cmd = 3'b000;
    int         irq_cnt = -1;
    bit         addr_phase = 1'b0;
    logic [7:0] rx_mem [0:1023];
    int         rx_cnt = 0;
    logic [7:0] tx_mem [0:1023];
    int         tx_ptr = 0;
    int         stop_cnt = 0;
    int         num_buses = 16;
    bit         force_al = 1'b0;
    bit         mute = 1'b0;

    always @(negedge clk) begin
        if (!rst_i) begin
            wb.ack_i = 1'b0;
            wb.irq_i = 1'b0;
            wb.dat_i = 8'h00;
            irq_cnt  = -1;
        end else begin
            if (irq_cnt > 0) begin
                irq_cnt--;
            end else if (irq_cnt == 0) begin
                irq_cnt = -1;
                m_stat  = 8'h80;
                case (m_cmd)
                    3'b110: if (m_dpr >= 8'(num_buses)) m_stat = 8'h10;
                    3'b100: begin addr_phase = 1'b1; if (force_al) m_stat = 8'h20; end
                    3'b001: begin
                        if (addr_phase) begin
                            addr_phase = 1'b0;
                            if (m_dpr[7:1] != 7'h22) m_stat = 8'h40;
                        end else begin
                            rx_mem[rx_cnt] = m_dpr;
                            rx_cnt++;
                        end
                    end
                    3'b010, 3'b011: begin m_dpr = tx_mem[tx_ptr]; tx_ptr++; end
                    3'b101: stop_cnt++;
                    default: m_stat = 8'h10;
                endcase
                wb.irq_i = 1'b1;
            end
            if (wb.cyc_o && wb.stb_o && !wb.ack_i) begin
                wb.ack_i = 1'b1;
                if (wb.we_o) begin
                    wlog[wcnt] = {wb.adr_o, wb.dat_o};
                    wcnt++;
                    if (wb.adr_o == 2'd1) m_dpr = wb.dat_o;
                    if (wb.adr_o == 2'd2) begin
                        m_cmd   = wb.dat_o[2:0];
                        irq_cnt = mute ? -1 : 3;
                    end
                end else begin
                    wb.dat_i = (wb.adr_o == 2'd2) ? m_stat : m_dpr;
                    if (wb.adr_o == 2'd2) wb.irq_i = 1'b0;
                end
            end else begin
                wb.ack_i = 1'b0;
            end
        end
    end

    // Write-byte source: a byte is taken when wr_valid && wr_ready at a rising edge.
    logic [7:0] wr_mem [0:511];
    int         wr_len = 0;
    int         wr_ptr = 0;
    bit         wr_taken = 1'b0;
    int         wr_rdy_cnt = 0;

    always @(negedge clk) begin
        if (!rst_i || done) begin
            wr_ptr   = 0;
            wr_taken = 1'b0;
        end else begin
            if (wr_taken) wr_ptr++;
            wr_taken = wr_valid && wr_ready;
        end
        if (wr_ready === 1'b1) wr_rdy_cnt++;
        wr_valid = (wr_ptr < wr_len);
        wr_data  = wr_mem[wr_ptr];
    end

    // Read-byte sink with an optional 50-cycle stall on byte index stall_at.
    logic [7:0] rd_mem [0:1023];
    int         rd_cnt = 0;
    int         stall_at = -1;
    int         stalled_idx = -1;
    int         stall_left = 0;
    logic [7:0] stall_data = 8'h00;
    int         stall_viol = 0;
    int         stall_w0 = 0;
    int         stall_w1 = -1;

    always @(negedge clk) begin
        if (!rst_i) begin
            rd_ready   = 1'b1;
            stall_left = 0;
        end else if (rd_valid && rd_cnt == stall_at && stalled_idx != stall_at) begin
            stalled_idx = stall_at;
            stall_left  = 50;
            stall_data  = rd_data;
            stall_w0    = wcnt;
            rd_ready    = 1'b0;
        end else if (stall_left > 0) begin
            stall_left--;
            if (rd_valid !== 1'b1 || rd_data !== stall_data) stall_viol++;
            rd_ready = 1'b0;
        end else begin
            rd_ready = 1'b1;
            if (rd_valid === 1'b1) begin
                rd_mem[rd_cnt] = rd_data;
                if (rd_cnt == stall_at) stall_w1 = wcnt;
                rd_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input int base, input logic [9:0] exp[$]);
        check($sformatf("%s.nwrites", tag), 32'(wcnt - base), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s.w%0d", tag, i), 32'(wlog[base + i]), 32'(exp[i]));
    endtask

    task automatic issue(input logic rnw, input logic [3:0] bus, input logic [6:0] addr, input logic [7:0] len);
        int n = 0;
        while (req_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        req_rnw   = rnw;
        req_bus   = bus;
        req_addr  = addr;
        req_len   = len;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [1:0] exp_st);
        int n = 0;
        while (done !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
        check($sformatf("%s.done", tag), 32'(done), 32'd1);
        check($sformatf("%s.status", tag), 32'(status), 32'(exp_st));
        check($sformatf("%s.ready_at_done", tag), 32'(req_ready), 32'd0);
        @(negedge clk);
        check($sformatf("%s.ready_after", tag), 32'(req_ready), 32'd1);
    endtask

    initial begin
        int base;
        int rx0;
        int rd0;
        int st0;
        int wr0;
        int n;

        repeat (3) @(negedge clk);
        check("rst.cyc", 32'(wb.cyc_o), 32'd0);
        check("rst.stb", 32'(wb.stb_o), 32'd0);
        check("rst.we", 32'(wb.we_o), 32'd0);
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.wr_ready", 32'(wr_ready), 32'd0);
        check("rst.rd_valid", 32'(rd_valid), 32'd0);
        check("rst.status", 32'(status), 32'd0);
        rst_i = 1'b1;

        // Write 3 bytes to 0x22 on bus 5, INIT write included.
        wr_mem[0] = 8'hA5; wr_mem[1] = 8'h5A; wr_mem[2] = 8'hFF; wr_len = 3;
        rx0 = rx_cnt;
        issue(1'b0, 4'd5, 7'h22, 8'd3);
        wait_done("wr3", 2'd0);
        check_log("wr3", 0, '{10'h0C0, 10'h105, 10'h206, 10'h204, 10'h144, 10'h201,
                              10'h1A5, 10'h201, 10'h15A, 10'h201, 10'h1FF, 10'h201, 10'h205});
        check("wr3.rx_n", 32'(rx_cnt - rx0), 32'd3);
        check("wr3.rx0", 32'(rx_mem[rx0]), 32'hA5);
        check("wr3.rx1", 32'(rx_mem[rx0 + 1]), 32'h5A);
        check("wr3.rx2", 32'(rx_mem[rx0 + 2]), 32'hFF);

        // Read 2 bytes from 0x22.
        wr_len = 0;
        tx_mem[tx_ptr] = 8'h3C; tx_mem[tx_ptr + 1] = 8'hC3;
        base = wcnt; rd0 = rd_cnt;
        issue(1'b1, 4'd5, 7'h22, 8'd2);
        wait_done("rd2", 2'd0);
        check_log("rd2", base, '{10'h105, 10'h206, 10'h204, 10'h145, 10'h201, 10'h202, 10'h203, 10'h205});
        check("rd2.n", 32'(rd_cnt - rd0), 32'd2);
        check("rd2.b0", 32'(rd_mem[rd0]), 32'h3C);
        check("rd2.b1", 32'(rd_mem[rd0 + 1]), 32'hC3);

        // Unacknowledged address 0x7F.
        wr_mem[0] = 8'h11; wr_mem[1] = 8'h22; wr_len = 2;
        base = wcnt; st0 = stop_cnt; wr0 = wr_rdy_cnt;
        issue(1'b0, 4'd5, 7'h7F, 8'd2);
        wait_done("nak", 2'd1);
        check_log("nak", base, '{10'h105, 10'h206, 10'h204, 10'h1FE, 10'h201, 10'h205});
        check("nak.stops", 32'(stop_cnt - st0), 32'd1);
        check("nak.wr_ready", 32'(wr_rdy_cnt - wr0), 32'd0);
        wr_len = 0;

        // Highest bus index, zero-length probe.
        base = wcnt;
        issue(1'b0, 4'd15, 7'h22, 8'd0);
        wait_done("bus15", 2'd0);
        check_log("bus15", base, '{10'h10F, 10'h206, 10'h204, 10'h144, 10'h201, 10'h205});

        // Bus out of range on an 8-bus controller: ERR, no Start.
        num_buses = 8;
        base = wcnt; st0 = stop_cnt;
        issue(1'b0, 4'd9, 7'h22, 8'd1);
        wait_done("buserr", 2'd3);
        check_log("buserr", base, '{10'h109, 10'h206});
        check("buserr.stops", 32'(stop_cnt - st0), 32'd0);
        num_buses = 16;

        // Arbitration lost on Start: no Stop.
        force_al = 1'b1;
        base = wcnt; st0 = stop_cnt;
        issue(1'b0, 4'd5, 7'h22, 8'd1);
        wait_done("al", 2'd2);
        check_log("al", base, '{10'h105, 10'h206, 10'h204});
        check("al.stops", 32'(stop_cnt - st0), 32'd0);
        force_al = 1'b0;

        // Controller never interrupts: timeout.
        mute = 1'b1;
        base = wcnt;
        issue(1'b0, 4'd5, 7'h22, 8'd1);
        wait_done("tmo", 2'd3);
        check_log("tmo", base, '{10'h105, 10'h206});
        mute = 1'b0;

        // Read with a 50-cycle stall on the first byte.
        tx_mem[tx_ptr] = 8'h96; tx_mem[tx_ptr + 1] = 8'h69;
        rd0 = rd_cnt; stall_at = rd_cnt;
        issue(1'b1, 4'd2, 7'h22, 8'd2);
        wait_done("stall", 2'd0);
        check("stall.b0", 32'(rd_mem[rd0]), 32'h96);
        check("stall.b1", 32'(rd_mem[rd0 + 1]), 32'h69);
        check("stall.viol", 32'(stall_viol), 32'd0);
        check("stall.no_write", 32'(stall_w1), 32'(stall_w0));

        // Maximum length: 255 bytes.
        for (int i = 0; i < 255; i++) wr_mem[i] = 8'(i) ^ 8'h5A;
        wr_len = 255;
        base = wcnt; rx0 = rx_cnt; wr0 = wr_rdy_cnt;
        issue(1'b0, 4'd5, 7'h22, 8'd255);
        wait_done("len255", 2'd0);
        check("len255.nwrites", 32'(wcnt - base), 32'd516);
        check("len255.rx_n", 32'(rx_cnt - rx0), 32'd255);
        check("len255.wr_ready", 32'(wr_rdy_cnt - wr0), 32'd255);
        check("len255.last", 32'(wlog[wcnt - 1]), 32'h205);
        for (int i = 0; i < 255; i++)
            check($sformatf("len255.rx%0d", i), 32'(rx_mem[rx0 + i]), 32'(8'(i) ^ 8'h5A));
        wr_len = 0;

        // Reset in the middle of a data byte.
        wr_mem[0] = 8'h01; wr_mem[1] = 8'h02; wr_mem[2] = 8'h03; wr_len = 3;
        rx0 = rx_cnt;
        issue(1'b0, 4'd5, 7'h22, 8'd3);
        n = 0;
        while (((rx_cnt - rx0) < 1 || wb.cyc_o !== 1'b1) && n < 5000) begin @(negedge clk); n++; end
        check("rstmid.in_cycle", 32'(wb.cyc_o), 32'd1);
        rst_i = 1'b0;
        @(negedge clk);
        check("rstmid.cyc", 32'(wb.cyc_o), 32'd0);
        check("rstmid.stb", 32'(wb.stb_o), 32'd0);
        check("rstmid.req_ready", 32'(req_ready), 32'd0);
        check("rstmid.wr_ready", 32'(wr_ready), 32'd0);
        wr_len = 0;
        @(negedge clk);
        rst_i = 1'b1;
        base = wcnt;
        n = 0;
        while (wcnt <= base && n < 1000) begin @(negedge clk); n++; end
        check("rstmid.init_csr", 32'(wlog[base]), 32'h0C0);
        wr_mem[0] = 8'h77; wr_len = 1;
        rx0 = rx_cnt;
        issue(1'b0, 4'd5, 7'h22, 8'd1);
        wait_done("after_rst", 2'd0);
        check("after_rst.rx_n", 32'(rx_cnt - rx0), 32'd1);
        check("after_rst.rx0", 32'(rx_mem[rx0]), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/iicmb_wb_sequencer.md
Name: iicmb_wb_sequencer

Overview:
- Synthesizable Wishbone master that sits directly upstream of the iicmb_m_wb I2C multi-bus controller and drives its byte-level register interface.
- Accepts one I2C transaction request at a time: bus select, 7-bit address, direction and length.
- Expands each request into the controller's command sequence: Set Bus, Start, address byte, data bytes, Stop.
- Streams write data in, streams read data out, and reports a completion status.

Parameters:
- WB_ADDR_WIDTH, 2, Wishbone address width (controller register select).
- WB_DATA_WIDTH, 8, Wishbone data width.
- LEN_WIDTH, 8, width of the byte-count field; 0 means address-only probe.
- TIMEOUT_CYCLES, 2000000, maximum clk_i cycles to wait for irq_i per command.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-low reset.
- cyc_o  out  1  Wishbone cycle.
- stb_o  out  1  Wishbone strobe.
- we_o  out  1  Wishbone write enable.
- adr_o  out  WB_ADDR_WIDTH  register select: 0 CSR, 1 DPR, 2 CMDR.
- dat_o  out  WB_DATA_WIDTH  write data to controller.
- dat_i  in  WB_DATA_WIDTH  read data from controller.
- ack_i  in  1  Wishbone acknowledge.
- irq_i  in  1  controller interrupt.
- req_valid  in  1  transaction request valid.
- req_ready  out  1  sequencer idle and able to accept a request.
- req_rnw  in  1  1 = read, 0 = write.
- req_bus  in  4  target bus index.
- req_addr  in  7  I2C slave address.
- req_len  in  LEN_WIDTH  number of data bytes.
- wr_valid  in  1  write byte valid.
- wr_ready  out  1  write byte consumed.
- wr_data  in  8  write byte.
- rd_valid  out  1  read byte valid.
- rd_ready  in  1  downstream accepts read byte.
- rd_data  out  8  read byte.
- done  out  1  one-cycle transaction-complete pulse.
- status  out  2  valid with done: 0 OK, 1 NAK, 2 arbitration lost, 3 error/timeout.

Behaviour:
- Reset (rst_i low on a clk_i edge):
  - All outputs 0; state returns to INIT.
  - Any Wishbone cycle in flight is abandoned: cyc_o/stb_o drop on the next edge.
- Wishbone access:
  - Single access: cyc_o = stb_o = 1, adr_o/dat_o/we_o held stable until the cycle where ack_i = 1; all three are deasserted on the following edge.
  - Exactly one access outstanding at any time.
  - Read data is sampled on the ack_i cycle.
- INIT: write CSR = 0xC0 (enable + interrupt enable), then go to IDLE. req_ready stays 0 until INIT completes.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch all req_* fields; req_ready drops the next cycle.
- Command step CMD(c), all steps the same shape:
  - Write CMDR = c.
  - Wait for irq_i = 1, counting cycles.
  - Read CMDR (this clears irq) and decode: bit7 DON, bit6 NAK, bit5 AL, bit4 ERR.
  - If the count reaches TIMEOUT_CYCLES, finish with status 3 and skip Stop.
- Transaction sequence:
  - Write DPR = bus, then CMD(SetBus = 3'b110).
  - CMD(Start = 3'b100).
  - Write DPR = {addr, rnw}, then CMD(Write = 3'b001).
  - Write path, per byte:
    - Wait for wr_valid, then assert wr_ready for exactly 1 cycle.
    - Write DPR = wr_data, then CMD(Write).
  - Read path, per byte:
    - CMD(ReadAck = 3'b010), or CMD(ReadNak = 3'b011) for the final byte.
    - Read DPR, present rd_data with rd_valid = 1, hold until rd_ready = 1.
  - CMD(Stop = 3'b101); pulse done with status 0; return to IDLE.
- Error priority per completion: AL > ERR > NAK > DON.
  - NAK: issue Stop, done with status 1.
  - ERR on SetBus (bus index out of range): done with status 3, no Stop.
  - AL: done with status 2, no Stop (bus lost).
- Boundary cases:
  - req_len = 0: address byte then Stop, i.e. a probe.
  - req_len = 2^LEN_WIDTH−1: the byte counter must not wrap early.
  - Back-to-back requests: req_ready reasserts on the cycle after done.
  - irq_i already high when a new command is written: ignored until that command's CMDR write has been acked.
  - ack_i arriving without cyc_o: ignored.

Test Plan:
- Write 3 bytes (0xA5, 0x5A, 0xFF) to addr 0x22 on bus 5 → Wishbone writes observed in this order:
  - CSR = 0xC0 (INIT only), DPR = 0x05, CMDR = 0x06, CMDR = 0x04, DPR = 0x44, CMDR = 0x01.
  - Then three DPR/CMDR = 0x01 pairs, CMDR = 0x05.
  - done with status 0; the I2C slave BFM receives all 3 bytes.
- Read 2 bytes from addr 0x22, slave BFM returns 0x3C, 0xC3 → commands ReadAck then ReadNak; rd_data 0x3C, 0xC3 in order; status 0.
- Address 0x7F with no slave ACK → Stop issued, done with status 1, wr_ready never asserted.
- req_bus = 15 with the controller built for 16 buses → SetBus completes OK; then req_bus out of range (controller reports ERR) → status 3, no Start issued.
- rd_ready held low for 50 cycles mid-read → rd_valid/rd_data held stable; no further CMDR write until the byte is accepted.
- rst_i low during a data byte → cyc_o/stb_o = 0 the next cycle; INIT rewrites CSR = 0xC0; the next request completes OK.
